// File: rtl/obuf_drain_if.sv
// Bus bundle for obuf_drain: job control, output-FIFO read port, downstream write port and status.
interface obuf_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                    start;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic [2*DATA_WIDTH-1:0] fifo_dout;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [2*DATA_WIDTH-1:0] wr_data;
    logic                    busy;
    logic                    done;
    logic                    start_err;

    // The drain block itself sits on the slave side.
    modport slave (
        input  start, base_addr, fifo_empty, fifo_dout, wr_ready,
        output fifo_rd_en, wr_valid, wr_addr, wr_data, busy, done, start_err
    );

    modport master (
        output start, base_addr, fifo_empty, fifo_dout, wr_ready,
        input  fifo_rd_en, wr_valid, wr_addr, wr_data, busy, done, start_err
    );
endinterface

// File: rtl/obuf_drain.sv
// Drains one job of NUM_CH*OUT_DIM*OUT_DIM words from the output FIFO and writes them
// downstream with channel/row/column addresses, through a 2-entry skid queue.
module obuf_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_DIM    = 3,
    parameter int NUM_CH     = 4,
    parameter int CH_STRIDE  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    obuf_drain_if.slave  bus
);
    localparam int TOTAL = NUM_CH * OUT_DIM * OUT_DIM;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int RC_W  = $clog2(OUT_DIM + 1);
    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int DW    = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      req_cnt_q, wr_cnt_q;
    logic                  inflight_q;
    logic [1:0]            occ_q;
    logic                  head_q;
    logic [DW-1:0]         q_data_q [2];
    logic [ADDR_WIDTH-1:0] q_addr_q [2];
    logic [RC_W-1:0]       col_q, row_q;
    logic [CH_W-1:0]       ch_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  start_err_q;

    logic                  start_ok, wr_valid, accept, last_accept, rd_en, wr_idx;
    logic [1:0]            occ_eff;
    logic [ADDR_WIDTH-1:0] cap_addr;

    assign start_ok    = bus.start && (state_q == IDLE);
    assign wr_valid    = (occ_q != 2'd0);
    assign accept      = wr_valid && bus.wr_ready;
    assign last_accept = accept && (wr_cnt_q == CNT_W'(TOTAL - 1));
    // Occupancy is taken after this cycle's accept so a full pipeline still pops every cycle;
    // queue + in-flight can never exceed two words.
    assign occ_eff     = occ_q - {1'b0, accept};
    assign rd_en       = (state_q == RUN) && !bus.fifo_empty
                         && (req_cnt_q < CNT_W'(TOTAL))
                         && ((occ_eff + {1'b0, inflight_q}) < 2'd2);
    assign wr_idx      = head_q ^ occ_q[0];
    assign cap_addr    = base_q
                         + ADDR_WIDTH'(ch_q) * ADDR_WIDTH'(CH_STRIDE)
                         + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(OUT_DIM)
                         + ADDR_WIDTH'(col_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (rd_en && (req_cnt_q == CNT_W'(TOTAL - 1))) state_d = FLUSH;
            FLUSH:   if (last_accept) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            base_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            head_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                req_cnt_q <= '0;
                wr_cnt_q  <= '0;
                base_q    <= bus.base_addr;
                col_q     <= '0;
                row_q     <= '0;
                ch_q      <= '0;
            end else begin
                if (rd_en)  req_cnt_q <= req_cnt_q + CNT_W'(1);
                if (accept) wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
                if (inflight_q) begin
                    if (col_q == RC_W'(OUT_DIM - 1)) begin
                        col_q <= '0;
                        if (row_q == RC_W'(OUT_DIM - 1)) begin
                            row_q <= '0;
                            ch_q  <= ch_q + CH_W'(1);
                        end else begin
                            row_q <= row_q + RC_W'(1);
                        end
                    end else begin
                        col_q <= col_q + RC_W'(1);
                    end
                end
            end
            inflight_q  <= rd_en;
            occ_q       <= occ_q + {1'b0, inflight_q} - {1'b0, accept};
            head_q      <= head_q ^ accept;
            start_err_q <= start_err_q | (bus.start && (state_q != IDLE));
        end
    end

    // Each queue slot captures the word returning from the FIFO when it is the tail.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_data_q[gi] <= '0;
                q_addr_q[gi] <= '0;
            end else if (inflight_q && (wr_idx == 1'(gi))) begin
                q_data_q[gi] <= bus.fifo_dout;
                q_addr_q[gi] <= cap_addr;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.wr_valid   = wr_valid;
    assign bus.wr_data    = wr_valid ? q_data_q[head_q] : '0;
    assign bus.wr_addr    = wr_valid ? q_addr_q[head_q] : '0;
    assign bus.busy       = (state_q == RUN) || (state_q == FLUSH);
    assign bus.done       = (state_q == DONE);
    assign bus.start_err  = start_err_q;
endmodule
